// File: rtl/pci_target.sv
// PCI target with configuration space, BAR0 and a small dword memory.
// Define PCI_TARGET_BURST_EN to allow multi-dword memory bursts; otherwise every
// memory access disconnects with data after the first data phase.
module pci_target #(
  parameter logic [15:0] VENDOR_ID = 16'h1234,
  parameter logic [15:0] DEVICE_ID = 16'h0001,
  parameter int unsigned MEM_AW    = 4
) (
  input  logic             PCI_CLK,
  input  logic             RESET_n,
  input  logic             IDSEL,
  input  logic             FRAME_n,
  input  logic             IRDY_n,
  inout  wire logic        DEVSEL_n,
  inout  wire logic        TRDY_n,
  inout  wire logic        STOP_n,
  input  logic [3:0]       C_BE,
  inout  wire logic [31:0] AD,
  inout  wire logic        PAR
);

  localparam int unsigned MemDepth = 2 ** MEM_AW;
  localparam int unsigned BarLsb   = MEM_AW + 2;

`ifdef PCI_TARGET_BURST_EN
  localparam bit BurstEn = 1'b1;
`else
  localparam bit BurstEn = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StWait, StData, StBackoff} state_e;

  state_e              state_q, state_d;
  logic                frame_prev_q;
  logic                is_cfg_q, is_cfg_d;
  logic                is_wr_q, is_wr_d;
  logic [5:0]          cfg_dw_q, cfg_dw_d;
  logic [MEM_AW-1:0]   idx_q, idx_d;
  logic                mem_en_q, mem_en_d;
  logic [31:BarLsb]    bar_q, bar_d;
  logic                own_q, own_d;
  logic                devsel_n_q, devsel_n_d;
  logic                trdy_n_q, trdy_n_d;
  logic                stop_n_q, stop_n_d;
  logic                ad_oe_q, ad_oe_d;
  logic [31:0]         ad_q, ad_d;
  logic                par_oe_q, par_oe_d;
  logic                par_q, par_d;
  logic [31:0]         mem_q [MemDepth];

  logic                addr_phase;
  logic                cfg_hit;
  logic                mem_hit;
  logic                xfer;
  logic                mem_we;
  logic                stop_first;
  logic [MEM_AW-1:0]   idx_inc;
  logic [31:0]         cfg_rdata;
  logic [31:BarLsb]    bar_wmask;

  assign addr_phase = (state_q == StIdle) && !FRAME_n && frame_prev_q && IRDY_n;
  assign cfg_hit    = (C_BE[3:1] == 3'b101) && IDSEL && (AD[1:0] == 2'b00);
  assign mem_hit    = (C_BE[3:1] == 3'b011) && mem_en_q && (AD[31:BarLsb] == bar_q);
  assign xfer       = (state_q == StData) && !trdy_n_q && !IRDY_n;
  assign idx_inc    = idx_q + 1'b1;

  always_comb begin
    cfg_rdata = '0;
    case (cfg_dw_q)
      6'd0:    cfg_rdata = {DEVICE_ID, VENDOR_ID};
      6'd1:    cfg_rdata[1] = mem_en_q;
      6'd4:    cfg_rdata[31:BarLsb] = bar_q;
      default: cfg_rdata = '0;
    endcase
  end

  always_comb begin
    bar_wmask = '0;
    for (int i = BarLsb; i < 32; i++) begin
      bar_wmask[i] = ~C_BE[i/8];
    end
  end

  always_comb begin
    state_d    = state_q;
    is_cfg_d   = is_cfg_q;
    is_wr_d    = is_wr_q;
    cfg_dw_d   = cfg_dw_q;
    idx_d      = idx_q;
    mem_en_d   = mem_en_q;
    bar_d      = bar_q;
    own_d      = own_q;
    devsel_n_d = devsel_n_q;
    trdy_n_d   = trdy_n_q;
    stop_n_d   = stop_n_q;
    ad_oe_d    = ad_oe_q;
    ad_d       = ad_q;
    // PAR trails the AD/C_BE it covers by one clock.
    par_oe_d   = ad_oe_q;
    par_d      = ^{ad_q, C_BE};
    mem_we     = 1'b0;
    stop_first = 1'b0;

    case (state_q)
      StIdle: begin
        if (addr_phase && (cfg_hit || mem_hit)) begin
          stop_first = cfg_hit || !BurstEn;
          is_cfg_d   = cfg_hit;
          is_wr_d    = C_BE[0];
          cfg_dw_d   = AD[7:2];
          idx_d      = AD[BarLsb-1:2];
          own_d      = 1'b1;
          devsel_n_d = 1'b0;
          if (C_BE[0]) begin
            state_d  = StData;
            trdy_n_d = 1'b0;
            stop_n_d = !stop_first;
          end else begin
            state_d  = StWait;
            trdy_n_d = 1'b1;
            stop_n_d = 1'b1;
          end
        end
      end

      // Read turnaround: AD goes out together with TRDY_n.
      StWait: begin
        stop_first = is_cfg_q || !BurstEn;
        state_d    = StData;
        trdy_n_d   = 1'b0;
        stop_n_d   = !stop_first;
        ad_oe_d    = 1'b1;
        ad_d       = is_cfg_q ? cfg_rdata : mem_q[idx_q];
      end

      StData: begin
        if (trdy_n_q) begin
          // Disconnected with data; STOP_n stays low until the initiator ends.
          if (FRAME_n) begin
            state_d    = StBackoff;
            devsel_n_d = 1'b1;
            trdy_n_d   = 1'b1;
            stop_n_d   = 1'b1;
            ad_oe_d    = 1'b0;
          end
        end else if (xfer) begin
          if (is_wr_q) begin
            if (is_cfg_q) begin
              if (cfg_dw_q == 6'd1 && !C_BE[0]) begin
                mem_en_d = AD[1];
              end
              if (cfg_dw_q == 6'd4) begin
                bar_d = (bar_q & ~bar_wmask) | (AD[31:BarLsb] & bar_wmask);
              end
            end else begin
              mem_we = 1'b1;
            end
          end
          idx_d = idx_inc;
          if (FRAME_n) begin
            state_d    = StBackoff;
            devsel_n_d = 1'b1;
            trdy_n_d   = 1'b1;
            stop_n_d   = 1'b1;
            ad_oe_d    = 1'b0;
          end else if (!stop_n_q) begin
            trdy_n_d = 1'b1;
            ad_oe_d  = 1'b0;
          end else if (!is_wr_q) begin
            ad_d = mem_q[idx_inc];
          end
        end
      end

      StBackoff: begin
        state_d = StIdle;
        own_d   = 1'b0;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge PCI_CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q      <= StIdle;
      frame_prev_q <= 1'b1;
      is_cfg_q     <= 1'b0;
      is_wr_q      <= 1'b0;
      cfg_dw_q     <= '0;
      idx_q        <= '0;
      mem_en_q     <= 1'b0;
      bar_q        <= '0;
      own_q        <= 1'b0;
      devsel_n_q   <= 1'b1;
      trdy_n_q     <= 1'b1;
      stop_n_q     <= 1'b1;
      ad_oe_q      <= 1'b0;
      ad_q         <= '0;
      par_oe_q     <= 1'b0;
      par_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_prev_q <= FRAME_n;
      is_cfg_q     <= is_cfg_d;
      is_wr_q      <= is_wr_d;
      cfg_dw_q     <= cfg_dw_d;
      idx_q        <= idx_d;
      mem_en_q     <= mem_en_d;
      bar_q        <= bar_d;
      own_q        <= own_d;
      devsel_n_q   <= devsel_n_d;
      trdy_n_q     <= trdy_n_d;
      stop_n_q     <= stop_n_d;
      ad_oe_q      <= ad_oe_d;
      ad_q         <= ad_d;
      par_oe_q     <= par_oe_d;
      par_q        <= par_d;
    end
  end

  // Memory has no reset; writes only happen from StData, which reset leaves.
  always_ff @(posedge PCI_CLK) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (!C_BE[b]) begin
          mem_q[idx_q][8*b +: 8] <= AD[8*b +: 8];
        end
      end
    end
  end

  assign DEVSEL_n = own_q    ? devsel_n_q : 1'bz;
  assign TRDY_n   = own_q    ? trdy_n_q   : 1'bz;
  assign STOP_n   = own_q    ? stop_n_q   : 1'bz;
  assign AD       = ad_oe_q  ? ad_q       : 32'hzzzz_zzzz;
  assign PAR      = par_oe_q ? par_q      : 1'bz;

endmodule

// File: tb/tb_pci_target.sv
// Directed bench for pci_target acting as bus initiator; released target lines
// are pulled up so "not driven" reads back as 1.
module tb_pci_target;

`ifdef PCI_TARGET_BURST_EN
  localparam bit BurstEn = 1'b1;
`else
  localparam bit BurstEn = 1'b0;
`endif

  logic        PCI_CLK = 1'b0;
  logic        RESET_n = 1'b0;
  logic        IDSEL   = 1'b0;
  logic        FRAME_n = 1'b1;
  logic        IRDY_n  = 1'b1;
  logic [3:0]  C_BE    = 4'h0;
  wire         DEVSEL_n;
  wire         TRDY_n;
  wire         STOP_n;
  wire         PAR;
  wire  [31:0] AD;
  logic [31:0] tb_ad    = 32'h0;
  logic        tb_ad_oe = 1'b0;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] sb_q[$];
  logic [31:0] bd [4];
  int          beat, stalls, guard;
  bit          stopped, fin;

  assign AD = tb_ad_oe ? tb_ad : 32'hzzzz_zzzz;

  pullup pu_devsel (DEVSEL_n);
  pullup pu_trdy   (TRDY_n);
  pullup pu_stop   (STOP_n);
  pullup pu_par    (PAR);

  pci_target dut (
    .PCI_CLK  (PCI_CLK),
    .RESET_n  (RESET_n),
    .IDSEL    (IDSEL),
    .FRAME_n  (FRAME_n),
    .IRDY_n   (IRDY_n),
    .DEVSEL_n (DEVSEL_n),
    .TRDY_n   (TRDY_n),
    .STOP_n   (STOP_n),
    .C_BE     (C_BE),
    .AD       (AD),
    .PAR      (PAR)
  );

  always #5 PCI_CLK = ~PCI_CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Single-phase read; called at a negedge with the bus idle.
  task automatic rd(input string tag, input logic [3:0] cmd, input logic [31:0] addr,
                    input logic idsel, input logic claim, input logic [31:0] exp,
                    input logic exp_stop);
    int cyc;
    logic [31:0] want;
    FRAME_n = 1'b0; tb_ad_oe = 1'b1; tb_ad = addr; C_BE = cmd; IDSEL = idsel;
    @(negedge PCI_CLK);
    FRAME_n = 1'b1; IRDY_n = 1'b0; tb_ad_oe = 1'b0; C_BE = 4'h0; IDSEL = 1'b0;
    check({tag, " devsel"}, DEVSEL_n, claim ? 32'd0 : 32'd1);
    check({tag, " trdy turnaround"}, TRDY_n, 32'd1);
    if (claim) sb_q.push_back(exp);
    cyc = 1;
    while (TRDY_n !== 1'b0 && cyc < 6) begin
      @(negedge PCI_CLK);
      cyc++;
    end
    if (claim) begin
      check({tag, " trdy latency"}, cyc, 32'd2);
      check({tag, " stop"}, STOP_n, exp_stop ? 32'd0 : 32'd1);
      want = sb_q.pop_front();
      check({tag, " data"}, AD, want);
      @(negedge PCI_CLK);
      check({tag, " par"}, PAR, {31'd0, ^{want, 4'h0}});
      check({tag, " devsel backoff"}, DEVSEL_n, 32'd1);
    end else begin
      check({tag, " no trdy"}, TRDY_n, 32'd1);
    end
    IRDY_n = 1'b1;
    @(negedge PCI_CLK);
  endtask

  // Single-phase write; called at a negedge with the bus idle.
  task automatic wr(input string tag, input logic [3:0] cmd, input logic [31:0] addr,
                    input logic idsel, input logic [31:0] data, input logic [3:0] be,
                    input logic claim);
    FRAME_n = 1'b0; tb_ad_oe = 1'b1; tb_ad = addr; C_BE = cmd; IDSEL = idsel;
    @(negedge PCI_CLK);
    FRAME_n = 1'b1; IRDY_n = 1'b0; tb_ad = data; C_BE = be; IDSEL = 1'b0;
    check({tag, " devsel"}, DEVSEL_n, claim ? 32'd0 : 32'd1);
    check({tag, " trdy"}, TRDY_n, claim ? 32'd0 : 32'd1);
    @(negedge PCI_CLK);
    IRDY_n = 1'b1; tb_ad_oe = 1'b0; C_BE = 4'h0;
    @(negedge PCI_CLK);
  endtask

  initial begin
    bd[0] = 32'h1111_0001;
    bd[1] = 32'h2222_0002;
    bd[2] = 32'h3333_0003;
    bd[3] = 32'h4444_0004;

    repeat (2) @(negedge PCI_CLK);
    check("reset devsel", DEVSEL_n, 32'd1);
    check("reset trdy", TRDY_n, 32'd1);
    check("reset stop", STOP_n, 32'd1);
    check("reset par", PAR, 32'd1);
    RESET_n = 1'b1;
    @(negedge PCI_CLK);

    rd("cfg id", 4'hA, 32'h0000_0000, 1'b1, 1'b1, 32'h0001_1234, 1'b1);
    rd("cfg cmd rst", 4'hA, 32'h0000_0004, 1'b1, 1'b1, 32'h0, 1'b1);
    rd("cfg bar rst", 4'hA, 32'h0000_0010, 1'b1, 1'b1, 32'h0, 1'b1);
    wr("cfg bar ones", 4'hB, 32'h0000_0010, 1'b1, 32'hFFFF_FFFF, 4'h0, 1'b1);
    rd("cfg bar mask", 4'hA, 32'h0000_0010, 1'b1, 1'b1, 32'hFFFF_FFC0, 1'b1);
    rd("cfg no idsel", 4'hA, 32'h0000_0010, 1'b0, 1'b0, 32'h0, 1'b0);
    wr("cfg bar set", 4'hB, 32'h0000_0010, 1'b1, 32'h8000_0000, 4'h0, 1'b1);
    rd("cfg bar rd", 4'hA, 32'h0000_0010, 1'b1, 1'b1, 32'h8000_0000, 1'b1);
    rd("mem disabled", 4'h6, 32'h8000_0004, 1'b0, 1'b0, 32'h0, 1'b0);
    wr("cfg cmd set", 4'hB, 32'h0000_0004, 1'b1, 32'hFFFF_FFFF, 4'h0, 1'b1);
    rd("cfg cmd rd", 4'hA, 32'h0000_0004, 1'b1, 1'b1, 32'h0000_0002, 1'b1);
    rd("cfg reserved", 4'hA, 32'h0000_0008, 1'b1, 1'b1, 32'h0, 1'b1);

    wr("mem zero", 4'h7, 32'h8000_0004, 1'b0, 32'h0, 4'h0, 1'b1);
    wr("mem be", 4'h7, 32'h8000_0004, 1'b0, 32'hDEAD_BEEF, 4'b1100, 1'b1);
    rd("mem be rd", 4'h6, 32'h8000_0004, 1'b0, 1'b1, 32'h0000_BEEF, !BurstEn);
    rd("mem miss", 4'h6, 32'h4000_0004, 1'b0, 1'b0, 32'h0, 1'b0);

    wr("pz 14", 4'h7, 32'h8000_0038, 1'b0, 32'h0, 4'h0, 1'b1);
    wr("pz 15", 4'h7, 32'h8000_003C, 1'b0, 32'h0, 4'h0, 1'b1);
    wr("pz 0", 4'h7, 32'h8000_0000, 1'b0, 32'h0, 4'h0, 1'b1);
    wr("pz 1", 4'h7, 32'h8000_0004, 1'b0, 32'h0, 4'h0, 1'b1);

    // Four-beat write burst from index 14, initiator stalls two clocks on beat 2.
    FRAME_n = 1'b0; tb_ad_oe = 1'b1; tb_ad = 32'h8000_0038; C_BE = 4'h7;
    @(negedge PCI_CLK);
    beat = 0; stalls = 0; guard = 0; stopped = 1'b0; fin = 1'b0;
    while (!fin && guard < 20) begin
      guard++;
      C_BE = 4'h0;
      if (stopped) begin
        FRAME_n = 1'b1; IRDY_n = 1'b0; fin = 1'b1;
        check("burst stop held", STOP_n, 32'd0);
        check("burst trdy off", TRDY_n, 32'd1);
      end else begin
        tb_ad = bd[beat];
        IRDY_n = (beat == 1 && stalls < 2);
        if (IRDY_n) begin
          stalls++;
          check("burst stall trdy", TRDY_n, 32'd0);
        end
        FRAME_n = (beat == 3 && !IRDY_n);
        if (!TRDY_n && !IRDY_n) begin
          if (beat == 0) check("burst stop beat1", STOP_n, BurstEn ? 32'd1 : 32'd0);
          if (!STOP_n && beat != 3) stopped = 1'b1;
          if (beat == 3) fin = 1'b1;
          beat++;
        end
      end
      @(negedge PCI_CLK);
    end
    IRDY_n = 1'b1; FRAME_n = 1'b1; tb_ad_oe = 1'b0;
    check("burst beats", beat, BurstEn ? 32'd4 : 32'd1);
    check("burst ended", fin, 32'd1);
    @(negedge PCI_CLK);

    rd("burst idx14", 4'h6, 32'h8000_0038, 1'b0, 1'b1, bd[0], !BurstEn);
    rd("burst idx15", 4'h6, 32'h8000_003C, 1'b0, 1'b1, BurstEn ? bd[1] : 32'h0, !BurstEn);
    rd("burst idx0", 4'h6, 32'h8000_0000, 1'b0, 1'b1, BurstEn ? bd[2] : 32'h0, !BurstEn);
    rd("burst idx1", 4'h6, 32'h8000_0004, 1'b0, 1'b1, BurstEn ? bd[3] : 32'h0, !BurstEn);

    // Reset during the read turnaround.
    FRAME_n = 1'b0; tb_ad_oe = 1'b1; tb_ad = 32'h0; C_BE = 4'hA; IDSEL = 1'b1;
    @(negedge PCI_CLK);
    FRAME_n = 1'b1; IRDY_n = 1'b0; tb_ad_oe = 1'b0; C_BE = 4'h0; IDSEL = 1'b0;
    check("rst wait devsel", DEVSEL_n, 32'd0);
    #1 RESET_n = 1'b0;
    #1;
    check("rst async devsel", DEVSEL_n, 32'd1);
    check("rst async trdy", TRDY_n, 32'd1);
    check("rst async stop", STOP_n, 32'd1);
    @(negedge PCI_CLK);
    check("rst held devsel", DEVSEL_n, 32'd1);
    IRDY_n = 1'b1; RESET_n = 1'b1;
    @(negedge PCI_CLK);

    rd("post rst id", 4'hA, 32'h0000_0000, 1'b1, 1'b1, 32'h0001_1234, 1'b1);
    rd("post rst bar", 4'hA, 32'h0000_0010, 1'b1, 1'b1, 32'h0, 1'b1);
    rd("post rst cmd", 4'hA, 32'h0000_0004, 1'b1, 1'b1, 32'h0, 1'b1);
    rd("post rst mem off", 4'h6, 32'h0000_0004, 1'b0, 1'b0, 32'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pci_target.md
PCI_TARGET -- requirements
Module: pci_target

Interface
REQ-001 Parameter VENDOR_ID, default 16'h1234: value returned in config dword 0x00 [15:0].
REQ-002 Parameter DEVICE_ID, default 16'h0001: value returned in config dword 0x00 [31:16].
REQ-003 Parameter MEM_AW, default 4: log2 of memory dwords; BAR0 window is 2^(MEM_AW+2) bytes.
REQ-004 PCI_CLK  input  1  bus clock; all logic samples on its rising edge.
REQ-005 RESET_n  input  1  asynchronous, active-low reset.
REQ-006 IDSEL  input  1  config-cycle select.
REQ-007 FRAME_n, IRDY_n  input  1 each  initiator controls.
REQ-008 DEVSEL_n, TRDY_n, STOP_n  inout  1 each  target controls; z when not owned.
REQ-009 C_BE  input  4  command (address phase) / byte enables (data phase, active low).
REQ-010 AD  inout  32  address/data; driven only during read data phases.
REQ-011 PAR  inout  1  even parity over AD and C_BE; driven one clock after the AD it covers.

Function
REQ-012 Address phase = rising edge with FRAME_n low, previous FRAME_n high and IRDY_n high; latch AD and C_BE.
REQ-013 Claim: cmd 4'hA/4'hB with IDSEL=1 and AD[1:0]=00; cmd 4'h6/4'h7 with Command bit1=1 and AD[31:MEM_AW+2] = BAR0 base. Others ignored, bus stays z.
REQ-014 States IDLE, WAIT, DATA, BACKOFF; IDLE->DATA (write claim) or IDLE->WAIT (read claim, AD turnaround) -> DATA.
REQ-015 DEVSEL_n driven low the clock after the address phase (fast decode); TRDY_n low with it for writes, one clock later for reads.
REQ-016 Read: AD driven with selected dword in the TRDY_n-low cycle; PAR driven the following clock.
REQ-017 Write: on clock with IRDY_n=0 and TRDY_n=0, store each byte whose C_BE bit is 0.
REQ-018 Last data phase = transfer with FRAME_n=1; then DATA->BACKOFF: DEVSEL_n/TRDY_n/STOP_n driven high one clock, AD z; then all z, IDLE.
REQ-019 TRDY_n held low while IRDY_n=1 (initiator wait); no data consumed or address advanced.
REQ-020 Config space: 0x00 IDs; 0x04 bit1 memory enable (RW), rest 0; 0x10 BAR0, bits [MEM_AW+1:0] read 0, upper RW; other dwords read 0, writes ignored.
REQ-021 Config cycles always disconnect-with-data: STOP_n low with TRDY_n in first data phase.
REQ-022 Memory address index = AD[MEM_AW+1:2]; burst increments by 1, wrapping modulo 2^MEM_AW.
REQ-023 If initiator deasserts FRAME_n with STOP_n asserted, transaction completes per REQ-018; STOP_n held low until FRAME_n=1.

Reset
REQ-024 RESET_n low: state IDLE; DEVSEL_n, TRDY_n, STOP_n, AD, PAR z immediately; Command=0, BAR0=0; memory contents undefined.
REQ-025 Reset asserted mid-transaction aborts it; no partial write after release.

Configuration
REQ-026 Macro PCI_TARGET_BURST_EN defined: memory transactions burst per REQ-022 until FRAME_n deasserts.
REQ-027 Macro PCI_TARGET_BURST_EN undefined: memory transactions disconnect-with-data (STOP_n with TRDY_n) on first data phase, like REQ-021.

Verification
REQ-028 Config write 0x10 = 32'hFFFFFFFF, config read 0x10 with IDSEL=1 -> 32'hFFFFFFC0 (MEM_AW=4); IDSEL=0 -> DEVSEL_n stays z.
REQ-029 Config read 0x00 -> 32'h00011234, DEVSEL_n low 1 clock after address, TRDY_n 2 clocks after, STOP_n low, PAR even.
REQ-030 Memory enabled, BAR0=32'h8000_0000: write 32'hDEADBEEF to 0x8000_0004 with C_BE=4'b1100, read back -> 32'h0000BEEF (pre-zeroed).
REQ-031 Memory access with Command bit1=0 -> no DEVSEL_n, AD/TRDY_n remain z (master abort).
REQ-032 4-dword burst write from index 14, IRDY_n stalled 2 clocks at beat 2 -> with BURST_EN indices 14,15,0,1 written; without, only 14 and STOP_n low on beat 1.
REQ-033 RESET_n low during read WAIT state -> all target outputs z same cycle; next config read completes normally.
